// File: rtl/osc_ccc_startup_seq.sv
// -----------------------------------------------------------------------------
// osc_ccc_startup_seq
//
// Power-up sequencer for a fabric CCC/PLL that is fed by the on-chip
// oscillators. It runs from the 50 MHz RC oscillator clock and steps
// through these phases:
//   1. Hold the PLL in powerdown while the oscillator settles.
//   2. Wait for lock, bounded by a timeout.
//   3. Require lock to stay up for a qualification window.
//   4. Release the fabric reset.
// If lock is lost, or never arrives, the sequencer retries from powerdown.
// After MAX_RETRIES retries it parks in FAIL.
//
// Ports
//   CLK              in   sequencer clock (RC oscillator fabric clock)
//   RESET            in   synchronous, active-high reset
//   ENABLE           in   1 = run the sequence, 0 = return to IDLE
//   PLL_LOCK         in   CCC lock, asynchronous to CLK
//   PLL_POWERDOWN_N  out  0 = CCC/PLL held in powerdown
//   FAB_RESET_N      out  active-low fabric reset
//   READY            out  clocks valid, fabric released
//   FAIL             out  retries exhausted
//   STATE            out  current state encoding (3 bits)
//   RETRY_CNT        out  retries consumed since IDLE (4 bits)
//   LOCK_LOSS_CNT    out  saturating count of RUN lock losses (8 bits);
//                         present only when OSC_LOCK_LOSS_CNT_EN is defined
//
// Optional feature macro: OSC_LOCK_LOSS_CNT_EN
// -----------------------------------------------------------------------------
module osc_ccc_startup_seq #(
   parameter int STARTUP_CYCLES = 5000,
   parameter int LOCK_TIMEOUT   = 50000,
   parameter int STABLE_CYCLES  = 256,
   parameter int MAX_RETRIES    = 3,
   parameter int CNT_W          = 17
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       PLL_LOCK,
   output logic       PLL_POWERDOWN_N,
   output logic       FAB_RESET_N,
   output logic       READY,
   output logic       FAIL,
   output logic [2:0] STATE,
`ifdef OSC_LOCK_LOSS_CNT_EN
   output logic [3:0] RETRY_CNT,
   output logic [7:0] LOCK_LOSS_CNT
`else
   output logic [3:0] RETRY_CNT
`endif
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PWRUP     = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_STABLE    = 3'd3,
      S_RUN       = 3'd4,
      S_RETRY     = 3'd5,
      S_FAIL      = 3'd6
   } state_t;

   // Each phase loads N-1 on entry and leaves when the count reaches 0.
   // That gives exactly N cycles in the phase.
   localparam logic [CNT_W-1:0] STARTUP_LOAD = CNT_W'(STARTUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       retry_nxt;
   logic             lock_meta, lock_s;

   assign STATE = state;

   // Two-flop synchronizer for the asynchronous PLL lock.
   // NOTE: the reset is synchronous, so it is sampled inside the clocked block
   // and does not appear in the sensitivity list.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every flop sample the old value,
         // so the two stages shift instead of collapsing into one.
         lock_meta <= PLL_LOCK;
         lock_s    <= lock_meta;
      end
   end

   always_comb begin
      // NOTE: default everything first so that no path through the case
      // infers a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      retry_nxt = RETRY_CNT;
      if (!ENABLE) begin
         // ENABLE=0 overrides every other transition.
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         retry_nxt = '0;
      end else begin
         case (state)
            S_IDLE: begin
               retry_nxt = '0;
               state_nxt = S_PWRUP;
               cnt_nxt   = STARTUP_LOAD;
            end
            S_PWRUP: begin
               if (cnt == '0) begin
                  state_nxt = S_WAIT_LOCK;
                  cnt_nxt   = TIMEOUT_LOAD;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            S_WAIT_LOCK: begin
               // Lock is tested before the timeout, so lock wins on the last cycle.
               if (lock_s) begin
                  state_nxt = S_STABLE;
                  cnt_nxt   = STABLE_LOAD;
               end else if (cnt == '0) begin
                  state_nxt = S_RETRY;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            S_STABLE: begin
               if (!lock_s) begin
                  state_nxt = S_RETRY;
                  cnt_nxt   = '0;
               end else if (cnt == '0) begin
                  state_nxt = S_RUN;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state_nxt = S_RETRY;
                  cnt_nxt   = '0;
               end
            end
            S_RETRY: begin
               if (RETRY_CNT == RETRY_MAX) begin
                  state_nxt = S_FAIL;
                  cnt_nxt   = '0;
               end else begin
                  retry_nxt = RETRY_CNT + 4'd1;
                  state_nxt = S_PWRUP;
                  cnt_nxt   = STARTUP_LOAD;
               end
            end
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
            default: begin
               // Encoding 7 is unreachable; recover to a clean IDLE.
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               retry_nxt = '0;
            end
         endcase
      end
   end

   // The outputs are decoded from the next state and registered here, so
   // they change on the same edge as STATE and never glitch.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state           <= S_IDLE;
         cnt             <= '0;
         RETRY_CNT       <= '0;
         PLL_POWERDOWN_N <= 1'b0;
         FAB_RESET_N     <= 1'b0;
         READY           <= 1'b0;
         FAIL            <= 1'b0;
      end else begin
         state           <= state_nxt;
         cnt             <= cnt_nxt;
         RETRY_CNT       <= retry_nxt;
         PLL_POWERDOWN_N <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) ||
                            (state_nxt == S_RUN);
         FAB_RESET_N     <= (state_nxt == S_RUN);
         READY           <= (state_nxt == S_RUN);
         FAIL            <= (state_nxt == S_FAIL);
      end
   end

`ifdef OSC_LOCK_LOSS_CNT_EN
   // Lock losses while running. Only RESET clears this count; ENABLE=0 does not,
   // so the history survives re-enables.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         LOCK_LOSS_CNT <= '0;
      end else if ((state == S_RUN) && (state_nxt == S_RETRY) && (LOCK_LOSS_CNT != 8'hFF)) begin
         LOCK_LOSS_CNT <= LOCK_LOSS_CNT + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_osc_ccc_startup_seq.sv
// -----------------------------------------------------------------------------
// tb_osc_ccc_startup_seq
//
// Directed bench for osc_ccc_startup_seq with short timing parameters:
// STARTUP_CYCLES=10, LOCK_TIMEOUT=20, STABLE_CYCLES=4, MAX_RETRIES=2.
// Each expected value is queued as the stimulus is applied. It is popped and
// compared when the sampled DUT output becomes due.
// -----------------------------------------------------------------------------
module tb_osc_ccc_startup_seq;

   logic       CLK;
   logic       RESET;
   logic       ENABLE;
   logic       PLL_LOCK;
   logic       PLL_POWERDOWN_N;
   logic       FAB_RESET_N;
   logic       READY;
   logic       FAIL;
   logic [2:0] STATE;
   logic [3:0] RETRY_CNT;
`ifdef OSC_LOCK_LOSS_CNT_EN
   logic [7:0] LOCK_LOSS_CNT;
   logic       en2, lock2;
   logic       pdn2, fab2, ready2, fail2;
   logic [2:0] state2;
   logic [3:0] retry2;
   logic [7:0] loss2;
`endif

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   osc_ccc_startup_seq #(
      .STARTUP_CYCLES(10), .LOCK_TIMEOUT(20), .STABLE_CYCLES(4),
      .MAX_RETRIES(2), .CNT_W(17)
   ) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .PLL_LOCK(PLL_LOCK),
      .PLL_POWERDOWN_N(PLL_POWERDOWN_N), .FAB_RESET_N(FAB_RESET_N),
      .READY(READY), .FAIL(FAIL), .STATE(STATE),
`ifdef OSC_LOCK_LOSS_CNT_EN
      .RETRY_CNT(RETRY_CNT), .LOCK_LOSS_CNT(LOCK_LOSS_CNT)
`else
      .RETRY_CNT(RETRY_CNT)
`endif
   );

`ifdef OSC_LOCK_LOSS_CNT_EN
   osc_ccc_startup_seq #(
      .STARTUP_CYCLES(10), .LOCK_TIMEOUT(20), .STABLE_CYCLES(4),
      .MAX_RETRIES(15), .CNT_W(17)
   ) dut2 (
      .CLK(CLK), .RESET(RESET), .ENABLE(en2), .PLL_LOCK(lock2),
      .PLL_POWERDOWN_N(pdn2), .FAB_RESET_N(fab2),
      .READY(ready2), .FAIL(fail2), .STATE(state2),
      .RETRY_CNT(retry2), .LOCK_LOSS_CNT(loss2)
   );
`endif

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Hard stop in case the bench itself stalls.
   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

`ifdef OSC_LOCK_LOSS_CNT_EN
   task automatic wait_state(input bit second, input logic [2:0] s, input int budget,
                             output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if ((second ? state2 : STATE) == s) begin
            ok = 1'b1;
            break;
         end
      end
   endtask
`endif

   initial begin
`ifdef OSC_LOCK_LOSS_CNT_EN
      bit ok, all_ok;
      en2   = 1'b0;
      lock2 = 1'b0;
`endif
      RESET    = 1'b1;
      ENABLE   = 1'b0;
      PLL_LOCK = 1'b0;

      // ---- reset state ----
      sb_push("rst_state", 0); sb_push("rst_pdn", 0); sb_push("rst_fab", 0);
      sb_push("rst_ready", 0); sb_push("rst_fail", 0); sb_push("rst_retry", 0);
      tick(2);
      check(STATE); check(PLL_POWERDOWN_N); check(FAB_RESET_N);
      check(READY); check(FAIL); check(RETRY_CNT);
      RESET = 1'b0;
      sb_push("idle_hold", 0);
      tick(1);
      check(STATE);

      // ---- 1. nominal power-up ----
      ENABLE = 1'b1;
      sb_push("t1_pdn_pre", 0); sb_push("t1_state_pwrup", 1);
      sb_push("t1_pdn_rise", 1); sb_push("t1_state_wait", 2);
      tick(10);
      check(PLL_POWERDOWN_N); check(STATE);
      tick(1);
      check(PLL_POWERDOWN_N); check(STATE);
      tick(5);
      PLL_LOCK = 1'b1;
      sb_push("t1_ready_pre", 0); sb_push("t1_ready", 1); sb_push("t1_fab", 1);
      sb_push("t1_retry", 0); sb_push("t1_state_run", 4);
      tick(6);
      check(READY);
      tick(1);
      check(READY); check(FAB_RESET_N); check(RETRY_CNT); check(STATE);

      // ---- 3. lock loss in RUN ----
      PLL_LOCK = 1'b0;
      sb_push("t3_ready_hold", 1); sb_push("t3_ready_drop", 0); sb_push("t3_fab_drop", 0);
      sb_push("t3_state_retry", 5); sb_push("t3_state_pwrup", 1);
      sb_push("t3_retry", 1); sb_push("t3_pdn", 0);
      tick(2);
      check(READY);
      tick(1);
      check(READY); check(FAB_RESET_N); check(STATE);
      tick(1);
      check(STATE); check(RETRY_CNT); check(PLL_POWERDOWN_N);
      sb_push("t3_pwrup_end", 1); sb_push("t3_wait", 2);
      tick(9);
      check(STATE);
      tick(1);
      check(STATE);
      tick(3);
      PLL_LOCK = 1'b1;
      sb_push("t3_ready_pre", 0); sb_push("t3_ready_back", 1); sb_push("t3_retry_run", 1);
      tick(6);
      check(READY);
      tick(1);
      check(READY); check(RETRY_CNT);

      // ---- 5b. RESET while in RUN ----
      RESET = 1'b1;
      sb_push("t5r_state", 0); sb_push("t5r_ready", 0); sb_push("t5r_fab", 0);
      sb_push("t5r_pdn", 0); sb_push("t5r_retry", 0);
      tick(1);
      check(STATE); check(READY); check(FAB_RESET_N); check(PLL_POWERDOWN_N); check(RETRY_CNT);
      PLL_LOCK = 1'b0;
      ENABLE   = 1'b0;
      tick(1);
      RESET = 1'b0;
      tick(1);

      // ---- 4. lock glitch in STABLE ----
      ENABLE = 1'b1;
      sb_push("t4_wait", 2);
      tick(11);
      check(STATE);
      PLL_LOCK = 1'b1;
      sb_push("t4_stable", 3);
      tick(3);
      check(STATE);
      PLL_LOCK = 1'b0;
      sb_push("t4_stable_hold", 3); sb_push("t4_ready_a", 0);
      tick(2);
      check(STATE); check(READY);
      PLL_LOCK = 1'b1;
      sb_push("t4_retry", 5); sb_push("t4_ready_b", 0);
      tick(1);
      check(STATE); check(READY);
      sb_push("t4_pwrup", 1); sb_push("t4_retry_cnt", 1); sb_push("t4_ready_c", 0);
      tick(1);
      check(STATE); check(RETRY_CNT); check(READY);

      // ---- 5a. ENABLE=0 mid WAIT_LOCK ----
      PLL_LOCK = 1'b0;
      sb_push("t5_wait", 2); sb_push("t5_wait_retry", 1); sb_push("t5_wait_pdn", 1);
      tick(10);
      check(STATE); check(RETRY_CNT); check(PLL_POWERDOWN_N);
      tick(5);
      ENABLE = 1'b0;
      sb_push("t5_state", 0); sb_push("t5_retry", 0); sb_push("t5_pdn", 0);
      sb_push("t5_ready", 0); sb_push("t5_fab", 0); sb_push("t5_fail", 0);
      tick(1);
      check(STATE); check(RETRY_CNT); check(PLL_POWERDOWN_N);
      check(READY); check(FAB_RESET_N); check(FAIL);

      // ---- lock on the final timeout cycle wins ----
      ENABLE = 1'b1;
      sb_push("lw_wait", 2);
      tick(11);
      check(STATE);
      tick(17);
      PLL_LOCK = 1'b1;
      sb_push("lw_wait_last", 2); sb_push("lw_stable", 3);
      tick(2);
      check(STATE);
      tick(1);
      check(STATE);
      ENABLE   = 1'b0;
      PLL_LOCK = 1'b0;
      sb_push("lw_idle", 0);
      tick(1);
      check(STATE);

      // ---- 2. lock timeout with retries exhausted ----
      ENABLE = 1'b1;
      for (int a = 0; a < 3; a++) begin
         sb_push("t2_wait_first", 2); sb_push("t2_wait_last", 2); sb_push("t2_retry", 5);
         tick(a == 0 ? 11 : 10);
         check(STATE);
         tick(19);
         check(STATE);
         tick(1);
         check(STATE);
         if (a < 2) begin
            sb_push("t2_pwrup", 1); sb_push("t2_retry_cnt", a + 1);
            tick(1);
            check(STATE); check(RETRY_CNT);
         end
      end
      sb_push("t2_state_fail", 6); sb_push("t2_fail", 1); sb_push("t2_pdn", 0);
      sb_push("t2_retry_final", 2); sb_push("t2_ready", 0);
      tick(1);
      check(STATE); check(FAIL); check(PLL_POWERDOWN_N); check(RETRY_CNT); check(READY);
      PLL_LOCK = 1'b1;
      sb_push("t2_sticky_state", 6); sb_push("t2_sticky_fail", 1);
      tick(40);
      check(STATE); check(FAIL);
      ENABLE = 1'b0;
      sb_push("t2_exit_state", 0); sb_push("t2_exit_fail", 0); sb_push("t2_exit_retry", 0);
      tick(1);
      check(STATE); check(FAIL); check(RETRY_CNT);

`ifdef OSC_LOCK_LOSS_CNT_EN
      // ---- 6a. lock-loss counter: two losses, survives ENABLE, cleared by RESET ----
      RESET    = 1'b1;
      PLL_LOCK = 1'b0;
      tick(2);
      RESET    = 1'b0;
      ENABLE   = 1'b1;
      PLL_LOCK = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sb_push("t6_run_ok", 1); sb_push("t6_retry_ok", 1);
         wait_state(1'b0, 3'd4, 100, ok);
         check(ok);
         PLL_LOCK = 1'b0;
         wait_state(1'b0, 3'd5, 10, ok);
         check(ok);
         PLL_LOCK = 1'b1;
      end
      sb_push("t6_loss2", 2);
      tick(1);
      check(LOCK_LOSS_CNT);
      ENABLE = 1'b0;
      tick(2);
      ENABLE = 1'b1;
      sb_push("t6_loss_after_en", 2);
      tick(1);
      check(LOCK_LOSS_CNT);
      RESET = 1'b1;
      sb_push("t6_loss_reset", 0);
      tick(1);
      check(LOCK_LOSS_CNT);
      RESET  = 1'b0;
      ENABLE = 1'b0;

      // ---- 6b. saturation at 255 ----
      en2    = 1'b1;
      all_ok = 1'b1;
      for (int k = 0; k < 300; k++) begin
         lock2 = 1'b1;
         tick(1);
         if (state2 == 3'd6) begin
            en2 = 1'b0;
            tick(1);
            en2 = 1'b1;
         end
         wait_state(1'b1, 3'd4, 100, ok);
         all_ok = all_ok & ok;
         lock2 = 1'b0;
         wait_state(1'b1, 3'd5, 10, ok);
         all_ok = all_ok & ok;
      end
      sb_push("t6_sat_waits", 1); sb_push("t6_sat", 255);
      check(all_ok);
      check(loss2);
`endif

      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL sb_leftover: observed %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
